hw_sw_mailbox: RTL and testbench
================================

# hw_sw_mailbox

Parametrised successor to the hardware/software communication block between the NIOS PIO ports and the game-drawing hardware. Software writes N data words on its PIO ports and commits them with a four-phase request/acknowledge handshake on the 2-bit signal lines. Committed words sit in a staging bank and move to the active bank only at a frame boundary, so the drawing logic always sees a coherent set of object parameters for a whole frame. Per-port masking lets selected ports, such as the HEX debug word, bypass double buffering.

## Interface
- NUM_PORTS, 16: number of hardware-bound data words (1..32).
- DATA_W, 32: width of each word.
- LIVE_MASK, 16'h8000: NUM_PORTS-bit mask; bit i set means port i is passed straight through, unbuffered.
- CNT_W, 16: width of the frame-commit counter.

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the design has a single clock.
- reset  in  1  asynchronous, active-high reset.
- to_hw_sig  in  2  from software; [0] = req, [1] = clr_overrun. Synchronous to clk.
- to_sw_sig  out  2  to software; [0] = ack, [1] = pending.
- sw_ports  in  NUM_PORTS*DATA_W  live PIO words, flattened; port i occupies [i*DATA_W +: DATA_W].
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- hw_ports  out  NUM_PORTS*DATA_W  active words presented to the drawing logic, same packing as sw_ports.
- frame_count  out  CNT_W  number of staging-to-active swaps.
- overrun  out  1  sticky; set when a commit overwrites a pending, undisplayed commit.

## Operation
- FSM states: IDLE and ACK.
- IDLE with req=1:
  - copy every buffered port of sw_ports into staging in one cycle;
  - set pending;
  - if pending was already 1, set overrun;
  - go to ACK.
- ACK: ack=1. Stay until req=0, then return to IDLE with ack=0. A req held high does not re-capture.
- Swap: frame_start=1 with pending=1 copies staging to active for buffered ports, clears pending, and increments frame_count. frame_count wraps from 2^CNT_W-1 to 0.
- frame_start with pending=0: no effect; frame_count does not change.
- Live ports (LIVE_MASK bit set): hw_ports word is a register loaded from sw_ports every cycle, regardless of the handshake. Their staging bits are unused.
- clr_overrun=1 clears overrun. If clear and set occur in the same cycle, set wins.
- Simultaneous capture and frame_start: the swap moves the old staging contents, the new capture lands in staging, and pending stays 1. overrun follows the pre-cycle value of pending.
- Reset (asserted at any time, including mid-handshake) forces:
  - state to IDLE;
  - ack, pending, overrun and frame_count to 0;
  - staging and active banks to 0.

  Software must restart the handshake after reset.

## Timing
- All outputs are registered. No combinational path exists from inputs to outputs.
- Commit latency:
  - req sampled high at edge N: staging is captured at edge N; ack and pending are high from cycle N+1.
  - req sampled low at edge M: ack is low from cycle M+1.
- Swap latency: frame_start sampled at edge F; hw_ports, frame_count and the pending clear are visible from F+1.
- Live ports: hw_ports word equals sw_ports one cycle later.
- overrun is visible one cycle after the capture edge.

## Structure
- Package veggie_comm_pkg holds:
  - state enum (ST_IDLE, ST_ACK);
  - bit indices SIG_REQ=0, SIG_CLR=1, SIG_ACK=0, SIG_PEND=1;
  - a function returning word i of a flattened bus.
- One sub-module, port_bank: a DATA_W register with load enable and async reset. It is instantiated per port for the staging and active banks through a generate loop keyed on LIVE_MASK.

## Test plan
- Basic commit: port0=32'hDEADBEEF, req pulsed for 3 cycles.
  - ack goes high 1 cycle after req, low 1 cycle after req drops.
  - hw_ports[0] stays 0 until frame_start, then reads DEADBEEF; frame_count=1; pending falls.
- Coherency: after commit, sw_ports changes to 32'h1234 without a new req, then frame_start occurs. hw_ports shows the committed value, not 32'h1234.
- Overrun: two commits (values 5, then 7) before any frame_start.
  - overrun=1; next swap gives 7.
  - clr_overrun pulse gives overrun=0.
- Simultaneous events: capture of 9 on the same edge as frame_start while staging holds 3.
  - active becomes 3; pending=1.
  - next frame_start gives active 9.
- Live port 15: write 32'h00C0FFEE with no handshake. hw_ports[15] follows one cycle later; frame_count is unchanged.
- Reset mid-ACK and counter wrap:
  - assert reset while ack=1: all outputs read 0 immediately.
  - with CNT_W=4, 16 swaps give frame_count=0.

Source files
------------

// File: rtl/veggie_comm_pkg.sv
// veggie_comm_pkg: shared types, signal bit indices and bus helpers for hw_sw_mailbox
package veggie_comm_pkg;
   typedef enum logic {ST_IDLE, ST_ACK} state_t;
   localparam int SIG_REQ  = 0;
   localparam int SIG_CLR  = 1;
   localparam int SIG_ACK  = 0;
   localparam int SIG_PEND = 1;
   localparam int MAX_BUS  = 2048;
   localparam int MAX_W    = 64;
   // Word i of a flattened bus of w-bit words; callers cast to their own width.
   function automatic logic [MAX_W-1:0] get_word(input logic [MAX_BUS-1:0] bus, input int unsigned i, input int unsigned w);
      return MAX_W'(bus >> (i * w));
   endfunction
endpackage

// File: rtl/port_bank.sv
// port_bank: W-bit register with load enable and async active-high reset
//   clk, reset : clock and async reset
//   i_load     : load enable
//   i_d / o_q  : data in / registered data out
module port_bank #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);
   always_ff @(posedge clk or posedge reset)
      if (reset) o_q <= '0;
      else if (i_load) o_q <= i_d;
endmodule

// File: rtl/hw_sw_mailbox.sv
// hw_sw_mailbox: frame-coherent double-buffered mailbox between software PIO words and drawing hardware
//   to_hw_sig   : [0] req, [1] clr_overrun from software
//   to_sw_sig   : [0] ack, [1] pending to software
//   sw_ports    : live software words, port i at [i*DATA_W +: DATA_W]
//   frame_start : vblank pulse; swaps staging into active when a commit is pending
//   hw_ports    : active words for the drawing logic
//   frame_count : number of swaps performed (wraps)
//   overrun     : sticky, a commit replaced one never displayed
module hw_sw_mailbox
   import veggie_comm_pkg::*;
#(
   parameter int                   NUM_PORTS = 16,
   parameter int                   DATA_W    = 32,
   parameter logic [NUM_PORTS-1:0] LIVE_MASK = 16'h8000,
   parameter int                   CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [1:0]                  to_hw_sig,
   output logic [1:0]                  to_sw_sig,
   input  logic [NUM_PORTS*DATA_W-1:0] sw_ports,
   input  logic                        frame_start,
   output logic [NUM_PORTS*DATA_W-1:0] hw_ports,
   output logic [CNT_W-1:0]            frame_count,
   output logic                        overrun
);
   state_t           r_state;
   logic             r_ack;
   logic             r_pend;
   logic             r_ovr;
   logic [CNT_W-1:0] r_cnt;
   logic             w_req;
   logic             w_clr;
   logic             w_cap;
   logic             w_swap;

   assign w_req  = to_hw_sig[SIG_REQ];
   assign w_clr  = to_hw_sig[SIG_CLR];
   assign w_cap  = (r_state == ST_IDLE) && w_req;
   assign w_swap = frame_start && r_pend;

   // Capture and swap in the same cycle leave pending set: the new capture still awaits a frame.
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= ST_IDLE;
         r_ack   <= 1'b0;
         r_pend  <= 1'b0;
         r_ovr   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_cap ? ST_ACK : (r_state == ST_ACK && !w_req) ? ST_IDLE : r_state;
         r_ack   <= w_cap | (r_ack & w_req);
         r_pend  <= w_cap | (r_pend & ~frame_start);
         r_ovr   <= (w_cap & r_pend) | (r_ovr & ~w_clr);
         r_cnt   <= r_cnt + CNT_W'(w_swap);
      end

   assign to_sw_sig[SIG_ACK]  = r_ack;
   assign to_sw_sig[SIG_PEND] = r_pend;
   assign frame_count         = r_cnt;
   assign overrun             = r_ovr;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      logic [DATA_W-1:0] w_sw;
      assign w_sw = DATA_W'(get_word(MAX_BUS'(sw_ports), i, DATA_W));
      if (LIVE_MASK[i]) begin : g_live
         port_bank #(.W(DATA_W)) u_live (
            .clk(clk), .reset(reset), .i_load(1'b1), .i_d(w_sw),
            .o_q(hw_ports[i*DATA_W +: DATA_W]));
      end else begin : g_buf
         logic [DATA_W-1:0] w_stage;
         port_bank #(.W(DATA_W)) u_stage (
            .clk(clk), .reset(reset), .i_load(w_cap), .i_d(w_sw), .o_q(w_stage));
         port_bank #(.W(DATA_W)) u_active (
            .clk(clk), .reset(reset), .i_load(w_swap), .i_d(w_stage),
            .o_q(hw_ports[i*DATA_W +: DATA_W]));
      end
   end
endmodule

// File: tb/tb_hw_sw_mailbox.sv
// tb_hw_sw_mailbox: directed self-checking bench for hw_sw_mailbox
module tb_hw_sw_mailbox;
   localparam int NP = 16;
   localparam int DW = 32;
   localparam int CW = 4;
   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       to_hw_sig = '0;
   logic [1:0]       to_sw_sig;
   logic [NP*DW-1:0] sw_ports = '0;
   logic             frame_start = 1'b0;
   logic [NP*DW-1:0] hw_ports;
   logic [CW-1:0]    frame_count;
   logic             overrun;
   int               total = 0;
   int               bad = 0;

   hw_sw_mailbox #(.NUM_PORTS(NP), .DATA_W(DW), .LIVE_MASK(16'h8000), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .to_hw_sig(to_hw_sig), .to_sw_sig(to_sw_sig),
      .sw_ports(sw_ports), .frame_start(frame_start), .hw_ports(hw_ports),
      .frame_count(frame_count), .overrun(overrun));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] hw(input int i);
      return hw_ports[i*DW +: DW];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic commit(input logic [31:0] v);
      sw_ports[0 +: DW] = v;
      to_hw_sig[0] = 1'b1;
      step();
      to_hw_sig[0] = 1'b0;
      step();
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   initial begin
      step();
      step();
      chk("rst_sig", 64'(to_sw_sig), 64'd0);
      chk("rst_cnt", 64'(frame_count), 64'd0);
      chk("rst_ovr", 64'(overrun), 64'd0);
      reset = 1'b0;
      step();
      chk("rst_hw0", 64'(hw(0)), 64'd0);
      // basic commit, req held three cycles
      sw_ports[0 +: DW] = 32'hDEADBEEF;
      to_hw_sig[0] = 1'b1;
      chk("ack_pre", 64'(to_sw_sig), 64'd0);
      step();
      chk("ack_hi", 64'(to_sw_sig), 64'd3);
      step();
      sw_ports[0 +: DW] = 32'h1234;
      step();
      chk("ack_hold", 64'(to_sw_sig), 64'd3);
      to_hw_sig[0] = 1'b0;
      step();
      chk("ack_lo", 64'(to_sw_sig), 64'd2);
      chk("hw0_before", 64'(hw(0)), 64'd0);
      chk("no_ovr_held_req", 64'(overrun), 64'd0);
      frame();
      chk("hw0_swap", 64'(hw(0)), 64'hDEADBEEF);
      chk("cnt1", 64'(frame_count), 64'd1);
      chk("pend_clr", 64'(to_sw_sig), 64'd0);
      // idle frame does nothing; sw 1234 never committed
      frame();
      chk("cnt_idle", 64'(frame_count), 64'd1);
      chk("coherent", 64'(hw(0)), 64'hDEADBEEF);
      // overrun
      commit(32'd5);
      chk("ovr_first", 64'(overrun), 64'd0);
      commit(32'd7);
      chk("ovr_set", 64'(overrun), 64'd1);
      frame();
      chk("ovr_val", 64'(hw(0)), 64'd7);
      chk("cnt2", 64'(frame_count), 64'd2);
      to_hw_sig[1] = 1'b1;
      step();
      to_hw_sig[1] = 1'b0;
      chk("ovr_clr", 64'(overrun), 64'd0);
      // simultaneous capture and swap
      commit(32'd3);
      sw_ports[0 +: DW] = 32'd9;
      to_hw_sig[0] = 1'b1;
      frame_start = 1'b1;
      step();
      to_hw_sig[0] = 1'b0;
      frame_start = 1'b0;
      chk("sim_act", 64'(hw(0)), 64'd3);
      chk("sim_sig", 64'(to_sw_sig), 64'd3);
      chk("sim_ovr", 64'(overrun), 64'd1);
      chk("sim_cnt", 64'(frame_count), 64'd3);
      step();
      frame();
      chk("sim_next", 64'(hw(0)), 64'd9);
      chk("cnt4", 64'(frame_count), 64'd4);
      // clear and set together: set wins
      commit(32'd4);
      sw_ports[0 +: DW] = 32'd6;
      to_hw_sig = 2'b11;
      step();
      to_hw_sig = 2'b00;
      chk("set_wins", 64'(overrun), 64'd1);
      step();
      frame();
      chk("last_wins", 64'(hw(0)), 64'd6);
      chk("cnt5", 64'(frame_count), 64'd5);
      // live port 15
      sw_ports[15*DW +: DW] = 32'h00C0FFEE;
      chk("live_pre", 64'(hw(15)), 64'd0);
      step();
      chk("live_post", 64'(hw(15)), 64'h00C0FFEE);
      chk("live_cnt", 64'(frame_count), 64'd5);
      chk("live_pend", 64'(to_sw_sig), 64'd0);
      // wrap: 11 more swaps from 5 reaches 16 -> 0
      for (int k = 0; k < 11; k++) begin
         commit(32'h100 + 32'(k));
         frame();
      end
      chk("wrap_cnt", 64'(frame_count), 64'd0);
      chk("wrap_hw0", 64'(hw(0)), 64'h10A);
      // reset while ack high with pending, overrun and count nonzero
      commit(32'h11);
      frame();
      chk("pre_rst_cnt", 64'(frame_count), 64'd1);
      commit(32'h22);
      sw_ports[0 +: DW] = 32'h33;
      to_hw_sig[0] = 1'b1;
      step();
      chk("pre_rst_sig", 64'(to_sw_sig), 64'd3);
      chk("pre_rst_ovr", 64'(overrun), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_sig", 64'(to_sw_sig), 64'd0);
      chk("arst_ovr", 64'(overrun), 64'd0);
      chk("arst_cnt", 64'(frame_count), 64'd0);
      chk("arst_hw0", 64'(hw(0)), 64'd0);
      chk("arst_hw15", 64'(hw(15)), 64'd0);
      to_hw_sig[0] = 1'b0;
      step();
      reset = 1'b0;
      frame();
      chk("post_rst_hw0", 64'(hw(0)), 64'd0);
      chk("post_rst_cnt", 64'(frame_count), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
